buffet_mem_port_arbiter: RTL
============================

Name: buffet_mem_port_arbiter

Overview:
Shares one single-port SRAM (64-bit data, 9-bit address) between the buffet write path and the buffet read path inside a fiber-access tile. It grants at most one memory operation per cycle using configurable priority with starvation protection. It also owns the one-cycle SRAM read return, buffering read data in a credit-checked response FIFO so that read-path backpressure never loses data.

Parameters:
DATA_WIDTH, 64, SRAM word width
ADDR_WIDTH, 9, SRAM address width
RSP_DEPTH, 2, response FIFO entries (power of 2, >=2)
MAX_STARVE, 4, consecutive losing cycles before the non-priority requester is forced through

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-HIGH (asserted = 1); name kept for uniformity with sibling blocks
clk_en  in  1  global clock enable; 0 freezes all state
flush  in  1  synchronous clear of all state, same effect as reset
tile_en  in  1  0 = block idle, no grants
cfg_wr_priority  in  1  1 = write wins ties, 0 = read wins ties
wr_addr  in  ADDR_WIDTH  write request address
wr_data  in  DATA_WIDTH  write request data
wr_valid  in  1  write request valid
wr_ready  out  1  write granted this cycle
rd_addr  in  ADDR_WIDTH  read request address
rd_valid  in  1  read request valid
rd_ready  out  1  read granted this cycle
rd_data  out  DATA_WIDTH  response FIFO head
rd_data_valid  out  1  response FIFO non-empty
rd_data_ready  in  1  consumer pops head
addr_to_mem  out  ADDR_WIDTH  SRAM address
data_to_mem  out  DATA_WIDTH  SRAM write data
wen_to_mem  out  1  SRAM write enable
ren_to_mem  out  1  SRAM read enable
data_from_mem  in  DATA_WIDTH  SRAM read data, valid 1 cycle after ren_to_mem
busy  out  1  read in flight or FIFO non-empty

Behaviour:
- Reset or flush: FIFO empty, pointers 0, inflight = 0, starve_cnt = 0. All outputs 0: rd_data_valid, busy, wen/ren, wr_ready, rd_ready, addr/data_to_mem.
- Grant is combinational in the same cycle. wr_ready = grant_wr. rd_ready = grant_rd. Ready never asserts without its valid.
- rd_eligible = rd_valid & (fifo_count + inflight < RSP_DEPTH). This is a credit check; fifo_count excludes the current-cycle pop, so no combinational path from rd_data_ready to rd_ready.
- Only one requester eligible: grant it.
- Both eligible:
  - The priority side wins.
  - Exception: if starve_cnt == MAX_STARVE, the other side wins and starve_cnt clears to 0.
- starve_cnt increments (saturating at MAX_STARVE) each cycle the non-priority side is eligible but not granted. It clears whenever the non-priority side is granted. A read blocked by credit does not count.
- grant_wr drives the SRAM: wen_to_mem = 1, addr_to_mem = wr_addr, data_to_mem = wr_data.
- grant_rd drives the SRAM: ren_to_mem = 1, addr_to_mem = rd_addr.
- No grant: addr_to_mem and data_to_mem = 0.
- inflight register: set to 1 on the cycle after grant_rd. On that cycle data_from_mem is pushed into the FIFO.
- Read latency from rd accept to rd_data_valid is 2 cycles; there is no bypass.
- FIFO push and pop in the same cycle are both honoured and the count is unchanged.
- Pop happens on rd_data_valid & rd_data_ready.
- FIFO responses return in grant order.
- Write followed by a read to the same address in a later cycle returns the new data.
- tile_en = 0: no new grants and starve_cnt holds. An in-flight read still lands in the FIFO, and pops still occur.
- clk_en = 0: all registers hold and wen/ren are forced to 0. Grants and readies are 0, so no handshake completes.
- Cycle with clk_en 1→0 while a read is in flight: data_from_mem is captured on the next enabled edge. The SRAM shares clk_en, so its output holds.
- Reset asserted mid-operation: immediate clear; in-flight data is discarded.
- busy = inflight | (fifo_count != 0).

Test Plan:
- Write-only: cfg_wr_priority = 1, writes to addresses 0..3 with data 0xA0..0xA3 back-to-back → wr_ready high every cycle, wen_to_mem pulses 4 times, ren_to_mem = 0.
- Readback: after the writes, reads of addresses 0..3 with rd_data_ready = 1 → rd_data = 0xA0..0xA3 in order, first rd_data_valid 2 cycles after the first rd accept, one read per cycle.
- Starvation: cfg_wr_priority = 1, wr_valid and rd_valid held high with MAX_STARVE = 4 → pattern of 4 write grants, 1 read grant, repeating, with starve_cnt back to 0 after each read grant.
- Backpressure: rd_data_ready = 0 with 5 reads requested → exactly 2 grants, then rd_ready low and busy = 1. Raising rd_data_ready drains 0xA0, 0xA1 and the remaining 3 reads complete in order.
- Simultaneous push/pop: FIFO holding 1 entry, pop and returning read in the same cycle → count stays 1, data order preserved.
- Reset/flush mid-read: rd accepted, then flush (and separately rst_n = 1) on the next edge → rd_data_valid stays 0, busy = 0, and the subsequent read returns correct data with 2-cycle latency.

Source files
------------

// File: rtl/buffet_mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the buffet write and read paths.
// Read returns go through a credit-checked response FIFO, so read-side backpressure never drops data.
module buffet_mem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int RSP_DEPTH  = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,
    input  logic                  cfg_wr_priority,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    output logic [DATA_WIDTH-1:0] data_to_mem,
    output logic                  wen_to_mem,
    output logic                  ren_to_mem,
    input  logic [DATA_WIDTH-1:0] data_from_mem,
    output logic                  busy
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [CW:0]   CREDITS    = (CW+1)'(RSP_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [SW-1:0]         starve_cnt, starve_nxt;

    logic act, wr_elig, rd_elig, pri_elig, np_elig, starved;
    logic grant_p, grant_np, grant_wr, grant_rd, push, pop;
    logic [CW:0] used;

    always_comb begin
        act      = clk_en & tile_en & ~rst_n & ~flush;
        // credit counts the in-flight read; the current-cycle pop is deliberately ignored
        used     = {1'b0, count} + {{CW{1'b0}}, inflight};
        rd_elig  = act & rd_valid & (used < CREDITS);
        wr_elig  = act & wr_valid;
        starved  = (starve_cnt == STARVE_MAX);
        pri_elig = cfg_wr_priority ? wr_elig : rd_elig;
        np_elig  = cfg_wr_priority ? rd_elig : wr_elig;
        grant_np = np_elig & (~pri_elig | starved);
        grant_p  = pri_elig & ~grant_np;
        grant_wr = cfg_wr_priority ? grant_p  : grant_np;
        grant_rd = cfg_wr_priority ? grant_np : grant_p;

        starve_nxt = starve_cnt;
        if (grant_np)
            starve_nxt = '0;
        else if (np_elig && !starved)
            starve_nxt = starve_cnt + 1'b1;

        push = inflight;
        pop  = rd_data_valid & rd_data_ready;
    end

    assign wr_ready      = grant_wr;
    assign rd_ready      = grant_rd;
    assign wen_to_mem    = grant_wr;
    assign ren_to_mem    = grant_rd;
    assign addr_to_mem   = grant_wr ? wr_addr : (grant_rd ? rd_addr : '0);
    assign data_to_mem   = grant_wr ? wr_data : '0;
    assign rd_data_valid = (count != '0);
    assign rd_data       = rd_data_valid ? fifo_mem[rptr] : '0;
    assign busy          = inflight | rd_data_valid;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            starve_cnt <= '0;
        end else if (clk_en) begin
            if (flush) begin
                wptr       <= '0;
                rptr       <= '0;
                count      <= '0;
                inflight   <= 1'b0;
                starve_cnt <= '0;
            end else begin
                inflight   <= grant_rd;
                starve_cnt <= starve_nxt;
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    // storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (clk_en && !rst_n && !flush && push)
            fifo_mem[wptr] <= data_from_mem;
    end
endmodule
